// File: rtl/sg_window_feeder.sv
// Sliding-window feeder for a Savitzky-Golay fitting engine.
// Streams DATA_SIZE samples out as WINDOW_SIZE-wide windows, one per valid centre.
module sg_window_feeder #(
    parameter int WINDOW_SIZE = 7,
    parameter int DATA_SIZE   = 1000,
    parameter int DATA_W      = 32,
    localparam int HALF       = WINDOW_SIZE / 2,
    localparam int IDX_W      = $clog2(DATA_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          done,
    output logic                          busy,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic [WINDOW_SIZE*DATA_W-1:0] win_data,
    output logic [IDX_W-1:0]              win_index
);

    localparam int CNT_W = $clog2(DATA_SIZE + 1);
    localparam int WIN_W = WINDOW_SIZE * DATA_W;

    localparam logic [CNT_W-1:0] DSZ = CNT_W'(DATA_SIZE);
    localparam logic [CNT_W-1:0] WSZ = CNT_W'(WINDOW_SIZE);
    localparam logic [CNT_W-1:0] OFS = CNT_W'(HALF + 1);
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(HALF);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_SIZE - 1 - HALF);

    if (DATA_SIZE < WINDOW_SIZE || WINDOW_SIZE < 3 || (WINDOW_SIZE % 2) == 0) begin : g_bad_cfg
        $error("sg_window_feeder: need odd WINDOW_SIZE >= 3 and DATA_SIZE >= WINDOW_SIZE");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   rcvd_q;
    logic [CNT_W-1:0]   rcvd_d;
    logic [WIN_W-1:0]   win_q;
    logic [WIN_W-1:0]   win_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic               win_valid_q;
    logic               done_q;
    logic               accept;

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            S_FILL:   in_ready = 1'b1;
            S_STREAM: in_ready = (!win_valid_q || win_ready) && (rcvd_q < DSZ);
            default:  in_ready = 1'b0;
        endcase
    end

    // Newest sample enters the top element; the oldest falls off element 0.
    assign accept = in_valid && in_ready;
    assign rcvd_d = rcvd_q + CNT_W'(1);
    assign win_d  = {in_data, win_q[WIN_W-1:DATA_W]};
    assign idx_d  = IDX_W'(rcvd_d - OFS);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rcvd_q      <= '0;
            win_q       <= '0;
            idx_q       <= '0;
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FILL;
                        rcvd_q  <= '0;
                        win_q   <= '0;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        win_q  <= win_d;
                        rcvd_q <= rcvd_d;
                        if (rcvd_d == WSZ) begin
                            win_valid_q <= 1'b1;
                            idx_q       <= FIRST_IDX;
                            state_q     <= (rcvd_d == DSZ) ? S_FLUSH : S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (accept) begin
                        win_q       <= win_d;
                        rcvd_q      <= rcvd_d;
                        win_valid_q <= 1'b1;
                        idx_q       <= idx_d;
                        if (rcvd_d == DSZ) begin
                            state_q <= S_FLUSH;
                        end
                    end else if (win_valid_q && win_ready) begin
                        win_valid_q <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (win_valid_q && win_ready && idx_q == LAST_IDX) begin
                        win_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);
    assign win_valid = win_valid_q;
    assign win_data  = win_q;
    assign win_index = idx_q;

endmodule

// File: tb/tb_sg_window_feeder.sv
// Directed bench for sg_window_feeder: default-size instance plus a
// minimum-size (DATA_SIZE=7) instance sharing clock and reset.
module tb_sg_window_feeder;

    localparam int WS   = 7;
    localparam int DW   = 32;
    localparam int DS   = 1000;
    localparam int HALF = 3;
    localparam int LAST = DS - 1 - HALF;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic             a_start = 1'b0;
    logic             a_done;
    logic             a_busy;
    logic             a_in_valid = 1'b0;
    logic             a_in_ready;
    logic [DW-1:0]    a_in_data = '0;
    logic             a_win_valid;
    logic             a_win_ready = 1'b0;
    logic [WS*DW-1:0] a_win_data;
    logic [9:0]       a_win_index;

    logic             b_start = 1'b0;
    logic             b_done;
    logic             b_busy;
    logic             b_in_valid = 1'b0;
    logic             b_in_ready;
    logic [DW-1:0]    b_in_data = '0;
    logic             b_win_valid;
    logic             b_win_ready = 1'b0;
    logic [WS*DW-1:0] b_win_data;
    logic [2:0]       b_win_index;

    sg_window_feeder u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (a_start),
        .done      (a_done),
        .busy      (a_busy),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .win_valid (a_win_valid),
        .win_ready (a_win_ready),
        .win_data  (a_win_data),
        .win_index (a_win_index)
    );

    sg_window_feeder #(.DATA_SIZE(7)) u_dut_min (
        .clk       (clk),
        .rst       (rst),
        .start     (b_start),
        .done      (b_done),
        .busy      (b_busy),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .win_valid (b_win_valid),
        .win_ready (b_win_ready),
        .win_data  (b_win_data),
        .win_index (b_win_index)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
                     tag, got, got, exp, exp);
        end
    endtask

    int k, sgn, exp_idx, nwin, ndone, acc_cnt, acc7_cyc, first_v, last_hs, stall;
    logic             prev_v, prev_hs;
    logic [WS*DW-1:0] prev_data;
    logic [9:0]       prev_idx;

    task automatic drive_data();
        a_in_data = a_in_valid ? 32'(sgn * k) : 32'hDEAD_BEEF;
    endtask

    // bp: hold win_ready low for 5 cycles of the first window.
    // bub: 0 none, 1 in_valid toggles starting high, 2 starting low.
    task automatic run(input int s, input bit bp, input int bub,
                       input int abort_idx, input int bs_idx, input int budget);
        bit acc, hs, fin;
        k = 0; sgn = s; exp_idx = HALF; nwin = 0; ndone = 0;
        acc_cnt = 0; acc7_cyc = -100; first_v = -1; last_hs = -100; stall = 0;
        prev_v = 1'b0; prev_hs = 1'b0; fin = 1'b0;
        a_win_ready = !bp;
        a_in_valid  = (bub != 2);
        drive_data();
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        for (int c = 0; c < budget && !fin; c++) begin
            @(negedge clk);
            acc = a_in_valid && a_in_ready;
            hs  = a_win_valid && a_win_ready;
            if (prev_v && !prev_hs) begin
                chk("hold_valid", 32'(a_win_valid), 32'd1);
                chk("hold_index", 32'(a_win_index), 32'(prev_idx));
                chk("hold_data", 32'(a_win_data == prev_data), 32'd1);
            end
            if (bp && a_win_valid && !a_win_ready) begin
                stall++;
                chk("bp_in_ready", 32'(a_in_ready), 32'd0);
            end
            if (acc) begin
                acc_cnt++;
                if (acc_cnt == WS) acc7_cyc = c;
            end
            if (a_win_valid && first_v < 0) begin
                first_v = c;
                chk("fill_latency", 32'(c - acc7_cyc), 32'd1);
            end
            if (hs) begin
                chk("win_index", 32'(a_win_index), 32'(exp_idx));
                for (int j = 0; j < WS; j++)
                    chk("win_elem", a_win_data[j*DW +: DW], 32'(sgn * (exp_idx - HALF + j)));
                last_hs = c;
                nwin++;
                exp_idx++;
            end
            if (a_done) begin
                ndone++;
                chk("done_latency", 32'(c - last_hs), 32'd1);
                fin = 1'b1;
            end
            prev_v    = a_win_valid;
            prev_hs   = hs;
            prev_data = a_win_data;
            prev_idx  = a_win_index;
            if (!fin) begin
                @(posedge clk); #1;
                if (acc) k++;
                if (bub != 0) a_in_valid = !a_in_valid;
                if (bp && stall >= 5) a_win_ready = 1'b1;
                a_start = (bs_idx >= 0) && hs &&
                          ((exp_idx - 1) == bs_idx || (exp_idx - 1) == LAST);
                drive_data();
                if (hs && (exp_idx - 1) == abort_idx) fin = 1'b1;
            end
        end
        if (!fin) chk("run_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int  kb, nb, nbd;
        bit  acc, hs, fin;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd0);
        chk("rst_win_valid", 32'(a_win_valid), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_win_index", 32'(a_win_index), 32'd0);
        chk("rst_win_data", 32'(a_win_data == '0), 32'd1);
        chk("rst_min_busy", 32'(b_busy), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        run(1, 1'b0, 0, -1, -1, 1200);
        chk("ramp_windows", 32'(nwin), 32'd994);
        chk("ramp_done_cnt", 32'(ndone), 32'd1);
        chk("ramp_first_win", 32'(first_v), 32'd7);
        chk("ramp_rate", 32'(last_hs - first_v), 32'd993);
        @(posedge clk); #1;
        chk("ramp_idle", 32'(a_busy), 32'd0);

        run(1, 1'b1, 0, -1, -1, 1200);
        chk("bp_stall_cycles", 32'(stall), 32'd5);
        chk("bp_windows", 32'(nwin), 32'd994);
        chk("bp_done_cnt", 32'(ndone), 32'd1);
        @(posedge clk); #1;

        run(1, 1'b0, 1, -1, -1, 2500);
        chk("bub10_windows", 32'(nwin), 32'd994);
        chk("bub10_first_win", 32'(first_v), 32'd13);
        @(posedge clk); #1;

        run(1, 1'b0, 2, -1, -1, 2500);
        chk("bub01_windows", 32'(nwin), 32'd994);
        chk("bub01_first_win", 32'(first_v), 32'd14);
        @(posedge clk); #1;

        run(1, 1'b0, 0, 100, -1, 1200);
        chk("abort_windows", 32'(nwin), 32'd98);
        chk("abort_no_done", 32'(ndone), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        chk("mid_rst_in_ready", 32'(a_in_ready), 32'd0);
        chk("mid_rst_win_valid", 32'(a_win_valid), 32'd0);
        chk("mid_rst_done", 32'(a_done), 32'd0);
        chk("mid_rst_win_index", 32'(a_win_index), 32'd0);
        chk("mid_rst_win_data", 32'(a_win_data == '0), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        run(-1, 1'b0, 0, -1, -1, 1200);
        chk("neg_windows", 32'(nwin), 32'd994);
        chk("neg_done_cnt", 32'(ndone), 32'd1);
        @(posedge clk); #1;

        run(1, 1'b0, 0, -1, 50, 1200);
        chk("busy_start_windows", 32'(nwin), 32'd994);
        chk("busy_start_done_cnt", 32'(ndone), 32'd1);
        @(posedge clk); #1;
        a_start = 1'b0;
        chk("start_in_done_busy", 32'(a_busy), 32'd0);
        @(posedge clk); #1;
        chk("start_in_done_idle", 32'(a_busy), 32'd0);
        chk("start_in_done_valid", 32'(a_win_valid), 32'd0);

        kb = 0; nb = 0; nbd = 0; fin = 1'b0;
        b_win_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = 32'd10;
        b_start     = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int c = 0; c < 30 && !fin; c++) begin
            @(negedge clk);
            acc = b_in_valid && b_in_ready;
            hs  = b_win_valid && b_win_ready;
            if (hs) begin
                nb++;
                chk("min_win_index", 32'(b_win_index), 32'd3);
                chk("min_in_ready", 32'(b_in_ready), 32'd0);
                for (int j = 0; j < WS; j++)
                    chk("min_win_elem", b_win_data[j*DW +: DW], 32'(10 + j));
            end
            if (b_done) begin
                nbd++;
                fin = 1'b1;
            end
            if (!fin) begin
                @(posedge clk); #1;
                if (acc) kb++;
                b_in_data = 32'(10 + kb);
            end
        end
        chk("min_windows", 32'(nb), 32'd1);
        chk("min_done_cnt", 32'(nbd), 32'd1);
        @(posedge clk); #1;
        chk("min_idle", 32'(b_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
